// File: rtl/ks_mp_add_sched_pkg.sv
// Shared definitions for the multi-precision add scheduler:
// FSM encoding, requester ids and the word-index width helper.
package ks_mp_add_sched_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic ID_REQ0 = 1'b0;
    localparam logic ID_REQ1 = 1'b1;

    // Word index width; a single-word build still needs a 1-bit index.
    function automatic int idx_w(input int words);
        if (words > 1) begin
            return $clog2(words);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/kogge_stone_Nbit_NOCLK.sv
// Purely combinational bw-bit Kogge-Stone adder. Vectors are indexed [bw:1];
// the carry-in is folded in as prefix position 0.
module kogge_stone_Nbit_NOCLK #(
    parameter int bw = 32
) (
    input  logic [bw:1] i_a,
    input  logic [bw:1] i_b,
    input  logic        i_cin,
    output logic [bw:1] o_sum,
    output logic        o_cout
);

    localparam int LV = $clog2(bw + 1);

    logic [bw:0] w_g [0:LV];
    logic [bw:0] w_p [0:LV];

    // Log-depth prefix tree; w_g[LV][i] is the carry out of positions 0..i.
    always_comb begin
        for (int l = 0; l <= LV; l++) begin
            w_g[l] = '0;
            w_p[l] = '0;
        end
        w_g[0] = {i_a & i_b, i_cin};
        w_p[0] = {i_a ^ i_b, 1'b0};
        for (int l = 1; l <= LV; l++) begin
            for (int i = 0; i <= bw; i++) begin
                if (i >= (1 << (l - 1))) begin
                    w_g[l][i] = w_g[l-1][i] | (w_p[l-1][i] & w_g[l-1][i - (1 << (l - 1))]);
                    w_p[l][i] = w_p[l-1][i] & w_p[l-1][i - (1 << (l - 1))];
                end else begin
                    w_g[l][i] = w_g[l-1][i];
                    w_p[l][i] = w_p[l-1][i];
                end
            end
        end
        o_sum  = w_p[0][bw:1] ^ w_g[LV][bw-1:0];
        o_cout = w_g[LV][bw];
    end

endmodule

// File: rtl/ks_mp_add_sched_rr_arb2.sv
// Two-way round-robin arbiter. The pointer names the favoured requester and
// moves to the other one whenever a grant is consumed.
module rr_arb2
    import ks_mp_add_sched_pkg::*;
(
    input  logic       CLK,
    input  logic       RESETn,
    input  logic [1:0] i_valid,
    input  logic       i_update,
    output logic [1:0] o_grant,
    output logic       o_grant_id
);

    logic r_ptr;

    // Grant selection: a lone requester always wins, a tie follows the pointer.
    always_comb begin
        o_grant    = 2'b00;
        o_grant_id = ID_REQ0;
        case (i_valid)
            2'b01: begin
                o_grant    = 2'b01;
                o_grant_id = ID_REQ0;
            end
            2'b10: begin
                o_grant    = 2'b10;
                o_grant_id = ID_REQ1;
            end
            2'b11: begin
                o_grant    = (r_ptr == ID_REQ1) ? 2'b10 : 2'b01;
                o_grant_id = r_ptr;
            end
            default: begin
                o_grant    = 2'b00;
                o_grant_id = ID_REQ0;
            end
        endcase
    end

    // Pointer update: favour the requester that was not just served.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_ptr <= ID_REQ0;
        end else if (i_update) begin
            r_ptr <= ~o_grant_id;
        end
    end

endmodule

// File: rtl/ks_mp_add_sched.sv
// Shares one BW-bit Kogge-Stone adder between two requesters; each request is
// a WORDS-word add run LS word first with the carry chained across cycles.
module ks_mp_add_sched
    import ks_mp_add_sched_pkg::*;
#(
    parameter int BW    = 32,
    parameter int WORDS = 4
) (
    input  logic                  CLK,
    input  logic                  RESETn,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [BW*WORDS-1:0]   req0_a,
    input  logic [BW*WORDS-1:0]   req0_b,
    input  logic                  req0_cin,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [BW*WORDS-1:0]   req1_a,
    input  logic [BW*WORDS-1:0]   req1_b,
    input  logic                  req1_cin,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [BW*WORDS-1:0]   rsp_sum,
    output logic                  rsp_cout,
    output logic                  rsp_id
);

    localparam int W  = BW * WORDS;
    localparam int IW = idx_w(WORDS);

    logic [1:0]    r_state;
    logic [IW-1:0] r_idx;
    logic          r_carry;
    logic [W-1:0]  r_a;
    logic [W-1:0]  r_b;
    logic [W-1:0]  r_sum;
    logic          r_cout;
    logic          r_id;
    logic          r_rsp_valid;

    logic [1:0]    w_grant;
    logic          w_grant_id;
    logic          w_acc;
    logic          w_last;
    logic [BW-1:0] w_a_word;
    logic [BW-1:0] w_b_word;
    logic [BW-1:0] w_add_sum;
    logic          w_add_cout;

    rr_arb2 u_arb (
        .CLK        (CLK),
        .RESETn     (RESETn),
        .i_valid    ({req1_valid, req0_valid}),
        .i_update   (w_acc),
        .o_grant    (w_grant),
        .o_grant_id (w_grant_id)
    );

    assign req0_ready = (r_state == ST_IDLE) & w_grant[0];
    assign req1_ready = (r_state == ST_IDLE) & w_grant[1];
    assign w_acc      = (req0_valid & req0_ready) | (req1_valid & req1_ready);
    assign w_last     = (r_idx == IW'(WORDS - 1));

    assign rsp_valid = r_rsp_valid;
    assign rsp_sum   = r_sum;
    assign rsp_cout  = r_cout;
    assign rsp_id    = r_id;

    // Operand word selection for the current index.
    always_comb begin
        w_a_word = '0;
        w_b_word = '0;
        for (int k = 0; k < WORDS; k++) begin
            if (r_idx == IW'(k)) begin
                w_a_word = r_a[k*BW +: BW];
                w_b_word = r_b[k*BW +: BW];
            end else begin
                w_a_word = w_a_word;
                w_b_word = w_b_word;
            end
        end
    end

    // Adder vectors are [BW:1], so word bit k lands on adder index k+1.
    kogge_stone_Nbit_NOCLK #(
        .bw (BW)
    ) u_add (
        .i_a    (w_a_word),
        .i_b    (w_b_word),
        .i_cin  (r_carry),
        .o_sum  (w_add_sum),
        .o_cout (w_add_cout)
    );

    // Control FSM: capture on request handshake, step words, hold result.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_state     <= ST_IDLE;
            r_idx       <= '0;
            r_carry     <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_cout      <= 1'b0;
            r_id        <= ID_REQ0;
            r_rsp_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_acc) begin
                        r_a     <= (w_grant_id == ID_REQ1) ? req1_a : req0_a;
                        r_b     <= (w_grant_id == ID_REQ1) ? req1_b : req0_b;
                        r_carry <= (w_grant_id == ID_REQ1) ? req1_cin : req0_cin;
                        r_id    <= w_grant_id;
                        r_idx   <= '0;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_carry <= w_add_cout;
                    if (w_last) begin
                        r_idx       <= '0;
                        r_cout      <= w_add_cout;
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end else begin
                        r_idx <= r_idx + IW'(1'b1);
                    end
                end
                ST_DONE: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

    // Result word write-back, one word per RUN cycle.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_sum <= '0;
        end else if (r_state == ST_RUN) begin
            for (int k = 0; k < WORDS; k++) begin
                if (r_idx == IW'(k)) begin
                    r_sum[k*BW +: BW] <= w_add_sum;
                end
            end
        end
    end

endmodule

// File: tb/tb_ks_mp_add_sched.sv
// Bench for ks_mp_add_sched (BW=8, WORDS=4): directed vector table, corner
// sequences, and randomized traffic against a plain-arithmetic model.
module tb_ks_mp_add_sched;

    localparam int BW    = 8;
    localparam int WORDS = 4;
    localparam int W     = BW * WORDS;

    logic          CLK = 1'b0;
    logic          RESETn;
    logic          req0_valid, req0_ready, req0_cin;
    logic [W-1:0]  req0_a, req0_b;
    logic          req1_valid, req1_ready, req1_cin;
    logic [W-1:0]  req1_a, req1_b;
    logic          rsp_valid, rsp_ready, rsp_cout, rsp_id;
    logic [W-1:0]  rsp_sum;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic        id;
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic [31:0] s;
        logic        co;
    } vec_t;

    typedef struct {
        logic        id;
        logic [32:0] res;
    } rsp_t;

    rsp_t expq[$];
    int   order_q[$];

    ks_mp_add_sched #(.BW(BW), .WORDS(WORDS)) dut (
        .CLK        (CLK),
        .RESETn     (RESETn),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_cin   (req0_cin),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_cin   (req1_cin),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_sum    (rsp_sum),
        .rsp_cout   (rsp_cout),
        .rsp_id     (rsp_id)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [32:0] ref_add(input logic [31:0] a, input logic [31:0] b, input logic c);
        return {1'b0, a} + {1'b0, b} + {32'd0, c};
    endfunction

    function automatic logic rdy(input int p);
        return (p == 0) ? req0_ready : req1_ready;
    endfunction

    task automatic set_req(input int p, input logic v, input logic [31:0] a, input logic [31:0] b, input logic c);
        if (p == 0) begin
            req0_valid = v; req0_a = a; req0_b = b; req0_cin = c;
        end else begin
            req1_valid = v; req1_a = a; req1_b = b; req1_cin = c;
        end
    endtask

    task automatic reset_dut();
        @(negedge CLK);
        RESETn = 1'b0;
        set_req(0, 1'b0, 32'd0, 32'd0, 1'b0);
        set_req(1, 1'b0, 32'd0, 32'd0, 1'b0);
        rsp_ready = 1'b0;
        repeat (2) @(negedge CLK);
        RESETn = 1'b1;
    endtask

    // Present one request alone; return once rsp_valid is seen (or timeout).
    task automatic issue_one(input int p, input logic [31:0] a, input logic [31:0] b, input logic c, output int lat);
        int n;
        @(negedge CLK);
        rsp_ready = 1'b0;
        set_req(p, 1'b1, a, b, c);
        #1;
        n = 0;
        while (!rdy(p) && n < 20) begin
            @(negedge CLK);
            #1;
            n++;
        end
        check("accept_timeout", 64'(n < 20), 64'd1);
        @(posedge CLK);
        @(negedge CLK);
        set_req(p, 1'b0, 32'd0, 32'd0, 1'b0);
        lat = 0;
        while (!rsp_valid && lat < 50) begin
            @(negedge CLK);
            lat++;
        end
    endtask

    task automatic rsp_take();
        rsp_ready = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        rsp_ready = 1'b0;
        #1;
        check("rsp_clear", 64'(rsp_valid), 64'd0);
    endtask

    // Both requesters stream n ops each; model checks grants and results.
    task automatic run_traffic(input int n_per_port, input bit rnd);
        logic [31:0] ca [2];
        logic [31:0] cb [2];
        logic        cc [2];
        int          rem [2];
        logic        v [2];
        logic [1:0]  er;
        logic        mptr;
        bit          busy;
        int          cyc;
        int          limit;
        rsp_t        e;
        reset_dut();
        expq.delete();
        order_q.delete();
        mptr  = 1'b0;
        busy  = 1'b0;
        cyc   = 0;
        limit = n_per_port * 2 * 40 + 100;
        for (int p = 0; p < 2; p++) begin
            rem[p] = n_per_port;
            ca[p] = $urandom; cb[p] = $urandom; cc[p] = 1'($urandom);
        end
        while ((rem[0] + rem[1] > 0 || busy) && cyc < limit) begin
            @(negedge CLK);
            for (int p = 0; p < 2; p++) begin
                v[p] = (rem[p] > 0) && (!rnd || $urandom_range(0, 3) != 0);
                if (!v[p]) begin
                    ca[p] = $urandom; cb[p] = $urandom; cc[p] = 1'($urandom);
                end
                set_req(p, v[p], ca[p], cb[p], cc[p]);
            end
            rsp_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            #1;
            er = 2'b00;
            if (!busy) begin
                if (v[0] && v[1]) er = mptr ? 2'b10 : 2'b01;
                else if (v[0])    er = 2'b01;
                else if (v[1])    er = 2'b10;
            end
            check("ready", 64'({req1_ready, req0_ready}), 64'(er));
            if (rsp_valid && rsp_ready) begin
                if (expq.size() == 0) begin
                    check("spurious_rsp", 64'(rsp_valid), 64'd0);
                end else begin
                    e = expq.pop_front();
                    check("rsp_sum_cout", {31'd0, rsp_cout, rsp_sum}, 64'(e.res));
                    check("rsp_id", 64'(rsp_id), 64'(e.id));
                end
                busy = 1'b0;
            end
            for (int p = 0; p < 2; p++) begin
                if (v[p] && rdy(p)) begin
                    e.id  = 1'(p);
                    e.res = ref_add(ca[p], cb[p], cc[p]);
                    expq.push_back(e);
                    order_q.push_back(p);
                    mptr = (p == 0);
                    busy = 1'b1;
                    rem[p]--;
                    ca[p] = $urandom; cb[p] = $urandom; cc[p] = 1'($urandom);
                end
            end
            cyc++;
        end
        check("traffic_complete", 64'((rem[0] + rem[1] == 0) && !busy), 64'd1);
        @(negedge CLK);
        set_req(0, 1'b0, 32'd0, 32'd0, 1'b0);
        set_req(1, 1'b0, 32'd0, 32'd0, 1'b0);
        rsp_ready = 1'b0;
    endtask

    initial begin
        vec_t vecs [7];
        int   exp_order [4];
        int   lat;
        logic flag;

        vecs[0] = '{1'b0, 32'h00FF_FFFF, 32'h0000_0001, 1'b0, 32'h0100_0000, 1'b0};
        vecs[1] = '{1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1};
        vecs[2] = '{1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1};
        vecs[3] = '{1'b1, 32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0};
        vecs[4] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1};
        vecs[5] = '{1'b1, 32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0};
        vecs[6] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0001, 1'b0};
        exp_order[0] = 0; exp_order[1] = 1; exp_order[2] = 0; exp_order[3] = 1;

        RESETn = 1'b0;
        reset_dut();
        #1;
        check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        check("reset_rsp_sum", 64'(rsp_sum), 64'd0);
        check("reset_rsp_cout", 64'(rsp_cout), 64'd0);
        check("reset_rsp_id", 64'(rsp_id), 64'd0);
        check("reset_readies", 64'({req1_ready, req0_ready}), 64'd0);

        // Both requesters busy from reset, two ops each.
        run_traffic(2, 1'b0);
        check("rr_order_len", 64'(order_q.size()), 64'd4);
        for (int i = 0; i < 4 && i < order_q.size(); i++) begin
            check("rr_order", 64'(order_q[i]), 64'(exp_order[i]));
        end

        // Directed vector table.
        for (int i = 0; i < 7; i++) begin
            issue_one(int'(vecs[i].id), vecs[i].a, vecs[i].b, vecs[i].cin, lat);
            check("vec_latency", 64'(lat), 64'(WORDS));
            check("vec_sum", 64'(rsp_sum), 64'(vecs[i].s));
            check("vec_cout", 64'(rsp_cout), 64'(vecs[i].co));
            check("vec_id", 64'(rsp_id), 64'(vecs[i].id));
            rsp_take();
        end

        // Backpressure in DONE: result held, no request accepted.
        issue_one(0, 32'h0F0F_0F0F, 32'h0101_0101, 1'b0, lat);
        for (int c = 0; c < 6; c++) begin
            set_req(0, 1'b1, 32'h1111_1111, 32'h2222_2222, 1'b0);
            set_req(1, 1'b1, 32'h3333_3333, 32'h4444_4444, 1'b1);
            #1;
            check("hold_valid", 64'(rsp_valid), 64'd1);
            check("hold_sum", 64'(rsp_sum), 64'h1010_1010);
            check("hold_cout_id", 64'({rsp_cout, rsp_id}), 64'd0);
            check("hold_readies", 64'({req1_ready, req0_ready}), 64'd0);
            @(negedge CLK);
        end
        rsp_ready = 1'b1;
        #1;
        check("hs_cycle_readies", 64'({req1_ready, req0_ready}), 64'd0);
        @(negedge CLK);
        rsp_ready = 1'b0;
        #1;
        check("after_hs_valid", 64'(rsp_valid), 64'd0);
        check("after_hs_one_ready", 64'(req0_ready + req1_ready), 64'd1);
        set_req(0, 1'b0, 32'd0, 32'd0, 1'b0);
        set_req(1, 1'b0, 32'd0, 32'd0, 1'b0);

        // Reset during RUN at idx 2 aborts the operation.
        @(negedge CLK);
        set_req(0, 1'b1, 32'h0102_0304, 32'h0101_0101, 1'b0);
        #1;
        check("abort_accept", 64'(req0_ready), 64'd1);
        @(posedge CLK);
        @(negedge CLK);
        set_req(0, 1'b0, 32'd0, 32'd0, 1'b0);
        repeat (2) @(negedge CLK);
        RESETn = 1'b0;
        #1;
        check("abort_valid", 64'(rsp_valid), 64'd0);
        check("abort_sum", 64'(rsp_sum), 64'd0);
        check("abort_cout_id", 64'({rsp_cout, rsp_id}), 64'd0);
        @(negedge CLK);
        RESETn = 1'b1;
        rsp_ready = 1'b1;
        flag = 1'b0;
        repeat (8) begin
            @(negedge CLK);
            if (rsp_valid) flag = 1'b1;
        end
        check("abort_no_rsp", 64'(flag), 64'd0);
        issue_one(1, 32'hDEAD_BEEF, 32'h2152_4111, 1'b0, lat);
        check("post_abort_sum_cout", {31'd0, rsp_cout, rsp_sum},
              64'(ref_add(32'hDEAD_BEEF, 32'h2152_4111, 1'b0)));
        check("post_abort_id", 64'(rsp_id), 64'd1);
        rsp_take();
        set_req(0, 1'b1, 32'd1, 32'd2, 1'b0);
        set_req(1, 1'b1, 32'd3, 32'd4, 1'b0);
        #1;
        check("post_abort_prio", 64'({req1_ready, req0_ready}), 64'b01);
        set_req(0, 1'b0, 32'd0, 32'd0, 1'b0);
        set_req(1, 1'b0, 32'd0, 32'd0, 1'b0);

        // Randomized traffic with backpressure and withdrawn requests.
        run_traffic(1500, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        n_errors++;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
